// File: rtl/tlqkf_load_ctrl.sv
// tlqkf_load_ctrl: fills the seven-slot tlqkf register file from the
// random generator, one non-zero sample per slot, with timeout and abort.
module tlqkf_load_ctrl #(
    parameter int DATA_W    = 7,
    parameter int NUM_SLOTS = 7,
    parameter int SKIP_ZERO = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_data_valid,
    output logic              o_rg_enb,
    output logic [2:0]        o_sel_reg,
    output logic              o_wr_en,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W+2:0] o_sum
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [2:0]    LAST_SLOT = 3'(NUM_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [2:0]          r_slot;
    logic [TW-1:0]       r_tmo;
    logic                r_rg_enb;
    logic [2:0]          r_sel_reg;
    logic                r_wr_en;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [DATA_W+2:0]   r_sum;
    logic                w_accept;

    // A sample is taken when valid, and zero is refused if skipping is on.
    assign w_accept = i_data_valid &&
                      ((SKIP_ZERO == 0) || (i_data_in != '0));

    // Run sequencer; every output is set on the transition into its state.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_tmo     <= '0;
            r_rg_enb  <= 1'b0;
            r_sel_reg <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sum     <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE, S_ERR: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b0;
                    end else if (i_start) begin
                        r_state   <= S_REQ;
                        r_slot    <= 3'd1;
                        r_tmo     <= '0;
                        r_sum     <= '0;
                        r_err     <= 1'b0;
                        r_rg_enb  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_sel_reg <= 3'd1;
                    end
                end
                S_REQ: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_tmo     <= '0;
                        r_rg_enb  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_sel_reg <= '0;
                    end else if (w_accept) begin
                        r_state   <= S_WRITE;
                        r_tmo     <= '0;
                        r_wr_data <= i_data_in;
                        r_wr_en   <= 1'b1;
                        r_rg_enb  <= 1'b0;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state   <= S_ERR;
                        r_tmo     <= '0;
                        r_err     <= 1'b1;
                        r_rg_enb  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_sel_reg <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WRITE: begin
                    // The strobe has been seen, so the value counts even on abort.
                    r_sum <= r_sum + {3'b000, r_wr_data};
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_sel_reg <= '0;
                    end else if (r_slot == LAST_SLOT) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_sel_reg <= '0;
                    end else begin
                        r_state   <= S_REQ;
                        r_slot    <= r_slot + 3'd1;
                        r_rg_enb  <= 1'b1;
                        r_sel_reg <= r_slot + 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rg_enb  = r_rg_enb;
    assign o_sel_reg = r_sel_reg;
    assign o_wr_en   = r_wr_en;
    assign o_wr_data = r_wr_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_sum     = r_sum;

endmodule

// File: tb/tb_tlqkf_load_ctrl.sv
// tb_tlqkf_load_ctrl: scoreboard bench for tlqkf_load_ctrl.
// A run-level model predicts each cycle's outputs; a monitor compares.
module tb_tlqkf_load_ctrl;

    localparam int DW = 7;
    localparam int NS = 7;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          dv;
    logic [DW-1:0] din;
    logic          o_rg_enb;
    logic [2:0]    o_sel_reg;
    logic          o_wr_en;
    logic [DW-1:0] o_wr_data;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [DW+2:0] o_sum;

    always #5 clk = ~clk;

    tlqkf_load_ctrl dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_data_in    (din),
        .i_data_valid (dv),
        .o_rg_enb     (o_rg_enb),
        .o_sel_reg    (o_sel_reg),
        .o_wr_en      (o_wr_en),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_sum        (o_sum)
    );

    typedef struct {
        int busy;
        int rg;
        int err;
        int wr;
        int dn;
        int sel;
        int sum;
    } snap_t;

    typedef struct {
        int sel;
        int data;
    } wr_t;

    snap_t sq[$];
    wr_t   wq[$];
    int    fq[$];

    int errors = 0;
    int checks = 0;

    // Run phases of the reference model.
    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_WR   = 2;
    localparam int P_DONE = 3;
    localparam int P_ERR  = 4;

    int m_ph   = P_IDLE;
    int m_slot = 0;
    int m_miss = 0;
    int m_sum  = 0;
    int m_err  = 0;
    int m_data = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     nm, $time, act, exp);
        end
    endtask

    // Advance the run model across one clock edge given that edge's inputs.
    task automatic model(input bit r, input bit s, input bit a,
                         input bit v, input int d);
        snap_t e;
        wr_t   w;
        if (!r) begin
            m_ph   = P_IDLE;
            m_slot = 0;
            m_miss = 0;
            m_sum  = 0;
            m_err  = 0;
        end else begin
            case (m_ph)
                P_IDLE, P_ERR: begin
                    if (a) begin
                        m_ph  = P_IDLE;
                        m_err = 0;
                    end else if (s) begin
                        m_ph   = P_WAIT;
                        m_slot = 1;
                        m_sum  = 0;
                        m_miss = 0;
                        m_err  = 0;
                    end
                end
                P_WAIT: begin
                    if (a) begin
                        m_ph = P_IDLE;
                    end else if (v && d != 0) begin
                        m_ph   = P_WR;
                        m_data = d;
                        m_miss = 0;
                        w.sel  = m_slot;
                        w.data = d;
                        wq.push_back(w);
                    end else begin
                        m_miss++;
                        if (m_miss == TO) begin
                            m_ph   = P_ERR;
                            m_err  = 1;
                            m_miss = 0;
                        end
                    end
                end
                P_WR: begin
                    m_sum += m_data;
                    if (a) m_ph = P_IDLE;
                    else if (m_slot == NS) m_ph = P_DONE;
                    else begin
                        m_slot++;
                        m_ph = P_WAIT;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
        e.busy = (m_ph == P_WAIT || m_ph == P_WR) ? 1 : 0;
        e.rg   = (m_ph == P_WAIT) ? 1 : 0;
        e.wr   = (m_ph == P_WR) ? 1 : 0;
        e.dn   = (m_ph == P_DONE) ? 1 : 0;
        e.sel  = e.busy ? m_slot : 0;
        e.err  = m_err;
        e.sum  = m_sum;
        sq.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit s, input bit a,
                       input bit v, input int d);
        @(negedge clk);
        rst_n = r;
        start = s;
        abort = a;
        dv    = v;
        din   = DW'(d);
        model(r, s, a, v, d);
    endtask

    // Offer the next queued sample only while a sample is being requested;
    // a queued -1 stands for a cycle with data_valid low.
    task automatic feed(input bit s, input bit a);
        int d;
        bit v;
        d = 0;
        v = 1'b0;
        if (m_ph == P_WAIT && fq.size() > 0) begin
            d = fq.pop_front();
            v = (d >= 0);
            if (d < 0) d = 0;
        end
        cyc(1'b1, s, a, v, d);
    endtask

    // Monitor: compare every cycle's outputs against the predicted snapshot.
    initial begin
        snap_t e;
        wr_t   w;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("busy", int'(o_busy), e.busy);
                chk("rg_enb", int'(o_rg_enb), e.rg);
                chk("err", int'(o_err), e.err);
                chk("wr_en", int'(o_wr_en), e.wr);
                chk("done", int'(o_done), e.dn);
                chk("sel_reg", int'(o_sel_reg), e.sel);
                chk("sum", int'(o_sum), e.sum);
                if (e.wr != 0 && wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("wr_sel", int'(o_sel_reg), w.sel);
                    chk("wr_data", int'(o_wr_data), w.data);
                end
            end
        end
    end

    initial begin
        int lim;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dv    = 1'b0;
        din   = '0;

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("reset_sum", int'(o_sum), 0);

        // Full run with samples 1..7.
        fq = {1, 2, 3, 4, 5, 6, 7};
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (16) feed(1'b0, 1'b0);
        chk("full_sum", int'(o_sum), 28);

        // Zero rejection and invalid cycles.
        fq = {0, 5, 0, 0, 9, -1, 1, 2, 0, 3, 4, 5};
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (24) feed(1'b0, 1'b0);
        chk("skip_sum", int'(o_sum), 29);

        // Starvation timeout, then restart clears err.
        fq.delete();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (20) feed(1'b0, 1'b0);
        chk("timeout_err", int'(o_err), 1);
        fq = {7, 7, 7, 7, 7, 7, 7};
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (16) feed(1'b0, 1'b0);
        chk("restart_err", int'(o_err), 0);
        chk("restart_sum", int'(o_sum), 49);

        // Abort in the request phase of slot 4.
        fq = {3, 4, 5, 6, 7, 8, 9};
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        lim = 0;
        while (!(m_ph == P_WAIT && m_slot == 4) && lim < 30) begin
            feed(1'b0, 1'b0);
            lim++;
        end
        feed(1'b0, 1'b1);
        repeat (4) feed(1'b0, 1'b0);
        chk("abort_sum", int'(o_sum), 12);

        // Start together with abort in idle stays idle.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Start during slot 3 is ignored.
        fq = {1, 1, 1, 1, 1, 1, 1};
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (16) feed((m_slot == 3) ? 1'b1 : 1'b0, 1'b0);
        chk("ign_start_sum", int'(o_sum), 7);

        // Reset during a write.
        fq = {10, 20, 30, 40, 50, 60, 70};
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        lim = 0;
        while (!(m_ph == P_WR && m_slot == 2) && lim < 30) begin
            feed(1'b0, 1'b0);
            lim++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("rst_mid_sum", int'(o_sum), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit s;
            bit a;
            bit v;
            int d;
            r = ($urandom_range(0, 299) != 0);
            s = ($urandom_range(0, 15) == 0);
            a = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127));
            cyc(r, s, a, v, d);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);

        @(posedge clk);
        #2;
        chk("queue_drained", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
